// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver:
// FSM state encoding, parity mode constants and the parity check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // x is the XOR of all data bits and the received parity bit
    function automatic logic parity_err(input int mode, input logic x);
        logic e;
        e = 1'b0;
        if (mode == PARITY_EVEN)
            e = x;
        else if (mode == PARITY_ODD)
            e = ~x;
        return e;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input;
// both flops load RST_VAL while reset is high.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta   <= RST_VAL;
            o_Sync <= RST_VAL;
        end else begin
            meta   <= i_Async;
            o_Sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data bits, parity, stop bits).
// Define UART_RX_BREAK_DETECT_EN to add the o_Break output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 o_Break
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    logic rx_s;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 sidx_q, sidx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 pbit_q, pbit_d;
    logic                 ferr_q, ferr_d;
    logic                 dv_q, dv_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 perr_q, perr_d;
    logic                 fe_q, fe_d;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 shi_q, shi_d;
    logic                 brk_q, brk_d;
`endif

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Async(i_Rx_Serial),
        .o_Sync (rx_s)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sidx_q  <= 1'b0;
            data_q  <= '0;
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            shi_q   <= 1'b0;
            brk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sidx_q  <= sidx_d;
            data_q  <= data_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
`ifdef UART_RX_BREAK_DETECT_EN
            shi_q   <= shi_d;
            brk_q   <= brk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sidx_d  = sidx_q;
        data_d  = data_q;
        pbit_d  = pbit_q;
        ferr_d  = ferr_q;
        dv_d    = 1'b0;
        byte_d  = byte_q;
        perr_d  = perr_q;
        fe_d    = fe_q;
`ifdef UART_RX_BREAK_DETECT_EN
        shi_d   = shi_q;
        brk_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                sidx_d = 1'b0;
                ferr_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                shi_d  = 1'b0;
`endif
                if (!rx_s)
                    state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ?
                                  ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    pbit_d  = rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_s;
`ifdef UART_RX_BREAK_DETECT_EN
                    shi_d  = shi_q | rx_s;
`endif
                    // leave at the last stop centre so a following start bit is caught
                    if (sidx_q == STOP_LAST) begin
                        state_d = ST_CLEANUP;
                        dv_d    = 1'b1;
                        byte_d  = data_q;
                        perr_d  = parity_err(PARITY_MODE, ^data_q ^ pbit_q);
                        fe_d    = ferr_q | ~rx_s;
`ifdef UART_RX_BREAK_DETECT_EN
                        brk_d   = (data_q == '0) && !shi_q && !rx_s &&
                                  ((PARITY_MODE == PARITY_NONE) || !pbit_q);
`endif
                    end else begin
                        sidx_d = 1'b1;
                    end
                end
            end
            ST_CLEANUP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = fe_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign o_Break      = brk_q;
`endif

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clock cycles per bit (10 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 0, parity: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 SHALL have port i_Clock  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port i_Reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port o_Rx_DV  output  1  one-cycle pulse, frame received.
REQ-009 SHALL have port o_Rx_Byte  output  DATA_BITS  received data, LSB first on line.
REQ-010 SHALL have port o_Parity_Err  output  1  parity mismatch of last frame.
REQ-011 SHALL have port o_Frame_Err  output  1  a stop bit sampled low in last frame.

Function
REQ-012 SHALL pass i_Rx_Serial through a two-flop synchroniser (reset value 1) before any use.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP.
REQ-014 IDLE: counters cleared; synchronised line low -> START.
REQ-015 START: count to (CLKS_PER_BIT-1)/2; line still low -> DATA, counter cleared; line high -> IDLE (glitch, no output).
REQ-016 DATA: sample every CLKS_PER_BIT cycles at bit centre into bit index 0..DATA_BITS-1; after last bit -> PARITY if PARITY_MODE!=0, else STOP.
REQ-017 PARITY: sample one bit; error when XOR(data, sampled bit) is 1 (even) or 0 (odd).
REQ-018 STOP: sample STOP_BITS bits at centre; any low sample sets frame error; after last stop sample -> CLEANUP.
REQ-019 CLEANUP: one cycle; o_Rx_DV=1, o_Rx_Byte/o_Parity_Err/o_Frame_Err updated same cycle; -> IDLE.
REQ-020 SHALL return to IDLE at centre of last stop bit (no wait to bit end) so back-to-back frames are received.
REQ-021 Frames with errors SHALL still assert o_Rx_DV; flags qualify the data.
REQ-022 o_Rx_Byte and flags SHALL hold their value until the next o_Rx_DV.
REQ-023 Clock counter width SHALL be $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS); no wrap within a bit.
REQ-024 Latency: o_Rx_DV rises 1 cycle after last stop-bit centre sample (plus 2-cycle synchroniser delay from line).

Reset
REQ-025 i_Reset high SHALL force state IDLE, counters 0, synchroniser flops 1, o_Rx_DV 0, o_Rx_Byte 0, both flags 0.
REQ-026 Reset mid-frame SHALL abort the frame with no o_Rx_DV; reception restarts on next falling edge after release.
REQ-027 Reset SHALL take priority over all state transitions in the same cycle.

Configuration
REQ-028 With UART_RX_BREAK_DETECT_EN defined: extra output o_Break (1 bit); pulses one cycle when data, parity and all stop samples of a frame are all 0; o_Rx_DV still asserted with o_Frame_Err=1.
REQ-029 Without UART_RX_BREAK_DETECT_EN: port o_Break and its logic absent; behaviour otherwise identical.

Structure
REQ-030 Package uart_pkg SHALL hold state encoding constants and PARITY_NONE/EVEN/ODD constants.
REQ-031 Synchroniser SHALL be sub-module uart_sync2 (two flops, reset value parameter).

Verification
REQ-032 8N1, CLKS_PER_BIT=87, send 0x55 -> one o_Rx_DV pulse, o_Rx_Byte=0x55, both flags 0.
REQ-033 8E1, send 0xA7 with parity bit 0 (wrong) -> o_Rx_DV, o_Rx_Byte=0xA7, o_Parity_Err=1.
REQ-034 8N2, send 0x3C with second stop bit low -> o_Rx_DV, o_Rx_Byte=0x3C, o_Frame_Err=1.
REQ-035 Line low 20 cycles then high -> no o_Rx_DV, state back to IDLE.
REQ-036 Back-to-back 0xA5,0x3C (7O1, DATA_BITS=7, values masked to 0x25,0x3C) -> two pulses, correct bytes, no errors; i_Reset mid-third frame -> no third pulse, outputs 0.
REQ-037 With UART_RX_BREAK_DETECT_EN, line low 2 frame times -> o_Break pulse, o_Rx_Byte=0x00, o_Frame_Err=1.
